// File: rtl/cpu_clk_ctrl_pkg.sv
// cpu_clk_ctrl_pkg: shared state encodings, widths and prescaler helper for cpu_clk_ctrl
package cpu_clk_ctrl_pkg;
  localparam int STATE_W = 2;
  localparam int PRE_W = 7;
  localparam int CYC_W = 16;
  typedef enum logic [STATE_W-1:0] {STOP = 2'd0, RUN = 2'd1, STEP = 2'd2} state_e;
  function automatic logic [PRE_W-1:0] pre_max(input logic [2:0] d);
    return PRE_W'((8'd1 << d) - 8'd1);
  endfunction
endpackage

// File: rtl/edge_det.sv
// edge_det: one-cycle rising-edge pulse, suppressing a level already high when rst releases
module edge_det (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic rise
);
  logic prev_q, prev_d, armed_q, armed_d;
  always_comb begin
    prev_d = in;
    armed_d = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
      armed_q <= armed_d;
    end
  end
  assign rise = armed_q && in && !prev_q;
endmodule

// File: rtl/cpu_clk_ctrl.sv
// cpu_clk_ctrl: run/step/halt CPU tick generator; CPU_CLK_CTRL_CYCLE_CNT_EN adds a cyc_cnt output
module cpu_clk_ctrl
  import cpu_clk_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               run_req,
  input  logic               step_req,
  input  logic               hlt_in,
  input  logic [2:0]         div_sel,
  output logic               clk_en,
  output logic [STATE_W-1:0] state,
  output logic               halted
`ifdef CPU_CLK_CTRL_CYCLE_CNT_EN
  ,
  output logic [CYC_W-1:0]   cyc_cnt
`endif
);
  state_e state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [2:0] d_q, d_d;
  logic halted_q, halted_d;
  logic step_rise, active, wrap;
  edge_det u_step_edge (.clk(clk), .rst(rst), .in(step_req), .rise(step_rise));
  always_comb begin
    active = state_q == RUN || state_q == STEP;
    wrap = pre_q == pre_max(d_q);
    clk_en = active && wrap && !hlt_in;
    state_d = STOP;
    pre_d = active ? (wrap ? '0 : pre_q + PRE_W'(1)) : pre_q;
    d_d = d_q;
    halted_d = halted_q;
    if (state_q == STOP && !halted_q && (run_req || step_rise)) begin
      state_d = run_req ? RUN : STEP;
      pre_d = '0;
      d_d = div_sel;
    end else if (active && hlt_in) halted_d = 1'b1;
    else if (state_q == RUN && run_req) state_d = RUN;
    else if (state_q == STEP && !clk_en) state_d = STEP;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= STOP;
      pre_q <= '0;
      d_q <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q <= pre_d;
      d_q <= d_d;
      halted_q <= halted_d;
    end
  end
  assign state = state_q;
  assign halted = halted_q;
`ifdef CPU_CLK_CTRL_CYCLE_CNT_EN
  logic [CYC_W-1:0] cyc_q, cyc_d;
  always_comb cyc_d = cyc_q + CYC_W'(clk_en);
  always_ff @(posedge clk) begin
    if (rst) cyc_q <= '0;
    else cyc_q <= cyc_d;
  end
  assign cyc_cnt = cyc_q;
`endif
endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// tb_cpu_clk_ctrl: table-driven and sequence checks of cpu_clk_ctrl with an expectation queue
module tb_cpu_clk_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1, run_req = 1'b0, step_req = 1'b0, hlt_in = 1'b0;
  logic [2:0] div_sel = 3'd0;
  logic clk_en, halted;
  logic [1:0] state;
`ifdef CPU_CLK_CTRL_CYCLE_CNT_EN
  logic [15:0] cyc_cnt;
`endif
  int errs = 0, checks = 0;
  always #5 clk = ~clk;
  cpu_clk_ctrl dut (
    .clk(clk), .rst(rst), .run_req(run_req), .step_req(step_req), .hlt_in(hlt_in),
    .div_sel(div_sel), .clk_en(clk_en), .state(state), .halted(halted)
`ifdef CPU_CLK_CTRL_CYCLE_CNT_EN
    , .cyc_cnt(cyc_cnt)
`endif
  );
  typedef struct {
    logic r, run, stp, hlt;
    logic [2:0] div;
    logic en;
    logic [1:0] st;
    logic h;
  } vec_t;
  typedef struct {
    logic en;
    logic [1:0] st;
    logic h;
  } exp_t;
  vec_t tv[$];
  exp_t sb[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive(input logic r, run, stp, hlt, input logic [2:0] div);
    @(negedge clk);
    rst = r;
    run_req = run;
    step_req = stp;
    hlt_in = hlt;
    div_sel = div;
    #1;
  endtask
  task automatic add(input logic r, run, stp, hlt, input logic [2:0] div, input logic en,
                     input logic [1:0] st, input logic h);
    tv.push_back('{r, run, stp, hlt, div, en, st, h});
  endtask
  initial begin
    exp_t e;
    int pulses, first, n;
    // reset with run_req high, then RUN with div 2 and a mid-RUN div change
    add(1,1,0,0,2, 0,0,0); add(1,1,0,0,2, 0,0,0); add(1,1,0,0,2, 0,0,0);
    add(0,1,0,0,2, 0,0,0); add(0,1,0,0,2, 0,1,0); add(0,1,0,0,2, 0,1,0);
    add(0,1,0,0,2, 0,1,0); add(0,1,0,0,2, 1,1,0); add(0,1,0,0,0, 0,1,0);
    add(0,1,0,0,0, 0,1,0); add(0,1,0,0,0, 0,1,0); add(0,1,0,0,0, 1,1,0);
    add(0,0,0,0,0, 0,1,0); add(0,0,0,0,0, 0,0,0);
    // held step_req with div 1: one pulse then STOP
    add(0,0,1,0,1, 0,0,0); add(0,0,1,0,1, 0,2,0); add(0,0,1,0,1, 1,2,0);
    add(0,0,1,0,1, 0,0,0); add(0,0,1,0,1, 0,0,0); add(0,0,0,0,1, 0,0,0);
    // run and step edge together, then halt in RUN and sticky halted
    add(0,1,1,0,0, 0,0,0); add(0,1,0,0,0, 1,1,0); add(0,1,0,1,0, 0,1,0);
    add(0,1,0,0,0, 0,0,1); add(0,1,1,0,0, 0,0,1); add(0,1,0,0,0, 0,0,1);
    // step_req high across reset release is not an edge
    add(1,0,1,0,0, 0,0,1); add(0,0,1,0,0, 0,0,0); add(0,0,1,0,0, 0,0,0);
    add(0,0,0,0,0, 0,0,0);
    // halt during STEP, then hlt_in in STOP is ignored
    add(0,0,1,0,0, 0,0,0); add(0,0,1,1,0, 0,2,0); add(0,0,0,0,0, 0,0,1);
    add(1,0,0,0,0, 0,0,1); add(0,0,0,1,0, 0,0,0); add(0,0,0,1,0, 0,0,0);
    // run_req ignored while in STEP
    add(0,0,0,0,0, 0,0,0); add(0,0,1,0,1, 0,0,0); add(0,1,1,0,1, 0,2,0);
    add(0,1,1,0,1, 1,2,0); add(0,1,0,0,1, 0,0,0); add(0,0,0,0,1, 0,1,0);
    add(0,0,0,0,1, 0,0,0);
    drive(1,1,0,0,2);
    foreach (tv[i]) begin
      drive(tv[i].r, tv[i].run, tv[i].stp, tv[i].hlt, tv[i].div);
      sb.push_back('{tv[i].en, tv[i].st, tv[i].h});
      e = sb.pop_front();
      chk($sformatf("vec%0d.clk_en", i), 32'(clk_en), 32'(e.en));
      chk($sformatf("vec%0d.state", i), 32'(state), 32'(e.st));
      chk($sformatf("vec%0d.halted", i), 32'(halted), 32'(e.h));
    end
    // 20 RUN cycles at div 2
    drive(1,0,0,0,2); drive(1,0,0,0,2); drive(0,1,0,0,2);
    pulses = 0; first = -1;
    for (int i = 0; i < 20; i++) begin
      drive(0,1,0,0,2);
      if (clk_en === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    chk("div2_pulses", 32'(pulses), 32'd5);
    chk("div2_first", 32'(first), 32'd3);
    drive(0,0,0,0,2);
`ifdef CPU_CLK_CTRL_CYCLE_CNT_EN
    chk("div2_cyc_cnt", 32'(cyc_cnt), 32'd5);
`endif
    // div 7: first pulse after 128 RUN cycles, bounded wait
    drive(1,0,0,0,7); drive(0,1,0,0,7);
    n = 0;
    while (n < 200) begin
      drive(0,1,0,0,7);
      if (clk_en === 1'b1) break;
      n++;
    end
    chk("div7_first", 32'(n), 32'd127);
    drive(1,1,0,0,7);
    drive(0,0,0,0,7);
    chk("rst_mid_run_state", 32'(state), 32'd0);
    chk("rst_mid_run_clk_en", 32'(clk_en), 32'd0);
`ifdef CPU_CLK_CTRL_CYCLE_CNT_EN
    drive(1,0,0,0,0); drive(0,1,0,0,0);
    for (int i = 0; i < 65537; i++) drive(0,1,0,0,0);
    drive(0,0,0,0,0);
    chk("cyc_cnt_wrap", 32'(cyc_cnt), 32'd1);
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/cpu_clk_ctrl.md
CPU_CLK_CTRL -- requirements
Module: cpu_clk_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset, sampled on rising clk.
REQ-003 SHALL have port run_req, input, 1, level; high requests free-running CPU ticks.
REQ-004 SHALL have port step_req, input, 1, raw level; each rising edge requests one CPU tick.
REQ-005 SHALL have port hlt_in, input, 1, CPU HLT indication.
REQ-006 SHALL have port div_sel, input, 3, tick period = 2^div_sel clk cycles.
REQ-007 SHALL have port clk_en, output, 1, one-cycle CPU clock-enable pulse.
REQ-008 SHALL have port state, output, 2, current FSM state encoding.
REQ-009 SHALL have port halted, output, 1, sticky HLT flag.

Function
REQ-010 SHALL implement states STOP=0, RUN=1, STEP=2; encoding 3 unreachable and SHALL recover to STOP next cycle.
REQ-011 SHALL detect step_req rising edge as registered-previous low, current high; edge valid for one cycle only.
REQ-012 STOP -> RUN when run_req=1 and halted=0; STOP -> STEP on step edge with run_req=0 and halted=0; run_req wins if both.
REQ-013 RUN -> STOP when run_req=0; no further clk_en after the transition edge.
REQ-014 STEP -> STOP in the cycle after its single clk_en pulse; step edges and run_req ignored while in STEP.
REQ-015 On entry to RUN or STEP: 7-bit prescaler cleared to 0 and div_sel latched into internal d; div_sel changes mid-RUN take no effect until next entry.
REQ-016 Prescaler increments each cycle in RUN/STEP and wraps to 0 after 2^d-1.
REQ-017 clk_en = (state is RUN or STEP) and prescaler == 2^d-1 and hlt_in=0; d=0 gives clk_en every cycle in RUN.
REQ-018 hlt_in=1 in RUN or STEP: clk_en suppressed that cycle, next state STOP, halted set to 1.
REQ-019 halted=1 blocks all STOP exits; cleared only by rst.
REQ-020 hlt_in in STOP SHALL have no effect.

Reset
REQ-021 rst=1 SHALL force state=STOP, prescaler=0, d=0, halted=0, step edge register=0, clk_en=0 in the following cycle, overriding all inputs including mid-RUN/STEP.
REQ-022 A step_req already high when rst deasserts SHALL NOT count as an edge.

Configuration
REQ-023 Macro CPU_CLK_CTRL_CYCLE_CNT_EN defined: SHALL add output cyc_cnt, 16 bits, incremented on each clk_en, wrapping 0xFFFF->0x0000, cleared by rst.
REQ-024 Macro undefined: cyc_cnt port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-025 Shared package cpu_clk_ctrl_pkg SHALL hold state encodings (STOP/RUN/STEP), STATE_W=2, PRE_W=7, CYC_W=16.
REQ-026 Step edge detection SHALL be sub-module edge_det (clk, rst, in, rise), reusable for other panel inputs.

Verification
REQ-027 rst high 3 cycles, run_req=1 during reset -> state=STOP, clk_en=0, halted=0 throughout; RUN one cycle after rst drops.
REQ-028 div_sel=2, run_req=1 for 20 cycles -> clk_en pulse every 4th cycle, first 4 cycles after RUN entry, 5 pulses total (cyc_cnt=5 with macro).
REQ-029 STOP, div_sel=1, step_req held high 10 cycles -> exactly one clk_en, 2 cycles after STEP entry, then state=STOP.
REQ-030 RUN, div_sel=0, hlt_in=1 for one cycle -> clk_en low that cycle, state=STOP next, halted=1; later run_req/step edges ignored until rst.
REQ-031 STOP, run_req rise and step edge same cycle -> state=RUN, no STEP.
REQ-032 Macro on, div_sel=0, run 65537 cycles -> cyc_cnt wraps to 1.
